// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input handshake.
// Direct mode holds one line until the next accept. Scan mode walks every line,
// SCAN_DWELL cycles each, starting at the accepted index, then pulses scan_done.
// Build option: define DEC_ACTIVE_LOW_EN for an active-low one-hot y (blank = all ones).
module decoder_nto2n_seq #(
  parameter int unsigned N          = 3,
  parameter int unsigned SCAN_DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        a,
  output logic [(2**N)-1:0]   y,
  output logic                out_valid,
  output logic                scan_done
);

  localparam int unsigned OUT_W = 2**N;
  localparam int unsigned DW    = $clog2(SCAN_DWELL + 1);

  localparam logic [DW-1:0] DwellLast = DW'(SCAN_DWELL - 1);
  localparam logic [N-1:0]  LineLast  = {N{1'b1}};

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] YBlank = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] YBlank = {OUT_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StScan
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [N-1:0]     lines_q, lines_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             scan_done_q, scan_done_d;
  logic             accept;
  logic             show;
  logic             done;

  // Not ready while scanning, nor on the scan_done cycle itself.
  assign in_ready = (state_q != StScan) && !scan_done_q;
  assign accept   = in_valid && in_ready;

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign scan_done = scan_done_q;

  // Next-state, scan counters and the pre-registered output value.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    lines_d  = lines_q;
    show     = 1'b0;
    done     = 1'b0;

    if (accept) begin
      // The accept edge is the first dwell cycle of the start line, even when blanked.
      idx_d   = a;
      dwell_d = '0;
      lines_d = '0;
      state_d = mode ? StScan : StHold;
      show    = 1'b1;
    end else begin
      case (state_q)
        StIdle: show = 1'b0;
        StHold: show = 1'b1;
        StScan: begin
          show = 1'b1;
          // en=0 freezes dwell/idx/lap progress; output is blanked below.
          if (en) begin
            if (dwell_q == DwellLast) begin
              dwell_d = '0;
              if (lines_q == LineLast) begin
                state_d = StIdle;
                show    = 1'b0;
                done    = 1'b1;
              end else begin
                idx_d   = idx_q + N'(1);
                lines_d = lines_q + N'(1);
              end
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    out_valid_d = en && show;
    y_d         = out_valid_d ? ((OUT_W'(1) << idx_d) ^ YBlank) : YBlank;
    scan_done_d = done;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dwell_q     <= '0;
      lines_q     <= '0;
      y_q         <= YBlank;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      lines_q     <= lines_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      scan_done_q <= scan_done_d;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq (N=3, SCAN_DWELL=2).
// The driver steps a schedule-based reference model each cycle and queues the
// expected post-edge outputs; a monitor pops and compares after every rising edge.
module tb_decoder_nto2n_seq;

  localparam int N     = 3;
  localparam int DWELL = 2;
  localparam int LINES = 8;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [7:0] BLANK = 8'hFF;
`else
  localparam logic [7:0] BLANK = 8'h00;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [7:0]   y;
  logic         out_valid;
  logic         scan_done;

  typedef struct packed {
    logic [7:0] y;
    logic       ov;
    logic       sd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference model: 0 idle, 1 hold, 2 scan; a scan is a list of visible line slots.
  int   m_st;
  int   m_line;
  bit   m_done;
  int   sched[$];

  decoder_nto2n_seq #(
    .N          (N),
    .SCAN_DWELL (DWELL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .y         (y),
    .out_valid (out_valid),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] line_val(input int line);
    logic [7:0] v;
    v = 8'(1 << line);
    return v ^ BLANK;
  endfunction

  task automatic model_reset();
    m_st   = 0;
    m_line = 0;
    m_done = 1'b0;
    sched.delete();
  endtask

  task automatic model_edge(input bit e, input bit md, input bit iv, input int av,
                            output exp_t r);
    bit ready;
    bit show;
    bit done;
    ready = (m_st != 2) && !m_done;
    show  = 1'b0;
    done  = 1'b0;
    if (iv && ready) begin
      if (md) begin
        sched.delete();
        for (int k = 0; k < LINES * DWELL; k++) sched.push_back((av + k / DWELL) % LINES);
        m_line = sched.pop_front();
        m_st   = 2;
      end else begin
        m_line = av;
        m_st   = 1;
      end
      show = 1'b1;
    end else if (m_st == 1) begin
      show = 1'b1;
    end else if (m_st == 2) begin
      show = 1'b1;
      if (e) begin
        if (sched.size() > 0) begin
          m_line = sched.pop_front();
        end else begin
          m_st = 0;
          show = 1'b0;
          done = 1'b1;
        end
      end
    end
    m_done = done;
    r.ov   = e && show;
    r.y    = r.ov ? line_val(m_line) : BLANK;
    r.sd   = done;
    r.rdy  = (m_st != 2) && !m_done;
  endtask

  // Called at a falling edge: drive inputs, queue expectation, wait for next falling edge.
  task automatic step(input bit e, input bit md, input bit iv, input int av);
    exp_t r;
    en       = e;
    mode     = md;
    in_valid = iv;
    a        = 3'(av);
    model_edge(e, md, iv, av, r);
    exp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic check_now(input string name);
    vectors++;
    if ({y, out_valid, scan_done, in_ready} !== {BLANK, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s: got y=%h ov=%b sd=%b rdy=%b, want y=%h ov=0 sd=0 rdy=1",
               name, y, out_valid, scan_done, in_ready, BLANK);
    end
  endtask

  // Asynchronous reset between edges, held across one rising edge.
  task automatic pulse_reset();
    exp_t r;
    #1 rst_n = 1'b0;
    #1 check_now("async_reset");
    model_reset();
    r.y   = BLANK;
    r.ov  = 1'b0;
    r.sd  = 1'b0;
    r.rdy = 1'b1;
    exp_q.push_back(r);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({y, out_valid, scan_done, in_ready} !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t: got y=%h ov=%b sd=%b rdy=%b, want y=%h ov=%b sd=%b rdy=%b",
                   $time, y, out_valid, scan_done, in_ready, e.y, e.ov, e.sd, e.rdy);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    en          = 1'b1;
    mode        = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_now("reset_state");
    rst_n = 1'b1;

    // Direct sweep, one accept per cycle, then hold.
    for (int i = 0; i < LINES; i++) step(1'b1, 1'b0, 1'b1, i);
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);

    // Full scan lap from line 6 with wrap.
    step(1'b1, 1'b1, 1'b1, 6);
    repeat (20) step(1'b1, 1'b0, 1'b0, 0);

    // Blank for 3 cycles on the first dwell cycle of line 1.
    step(1'b1, 1'b1, 1'b1, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    repeat (20) step(1'b1, 1'b0, 1'b0, 0);

    // Request held during a scan; accepted the cycle after scan_done.
    step(1'b1, 1'b1, 1'b1, 0);
    repeat (22) step(1'b1, 1'b0, 1'b1, 1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);

    // Reset mid-scan.
    step(1'b1, 1'b1, 1'b1, 3);
    repeat (5) step(1'b1, 1'b0, 1'b0, 0);
    pulse_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);

    // Accepts while blanked, then enable restored.
    step(1'b0, 1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 5);
    repeat (2) step(1'b0, 1'b0, 1'b0, 0);
    repeat (20) step(1'b1, 1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, int'($urandom_range(0, LINES - 1)));
    end
    pulse_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);

    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
